// File: rtl/sample_epoch_cnt.sv
// Two-level sample/epoch sequencer with IDLE/RUN/DONE control.
// Define CNT_DOWN_EN to add the 'dir' port for down-counting the sample index.
module sample_epoch_cnt #(
  parameter int IDX_W      = 8,
  parameter int SAMPLES    = 200,
  parameter int EP_W       = 8,
  parameter int MAX_EPOCHS = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             start,
  input  logic             enable,
  input  logic             stop_req,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_val,
`ifdef CNT_DOWN_EN
  input  logic             dir,
`endif
  output logic [IDX_W-1:0] idx,
  output logic [EP_W-1:0]  epoch,
  output logic             last_idx,
  output logic             epoch_tick,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_UP = IDX_W'(SAMPLES - 1);
  localparam logic [EP_W-1:0]  LAST_EP = EP_W'(MAX_EPOCHS - 1);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx_n;
  logic [EP_W-1:0]  epoch_n;
  logic             stop_pend, stop_pend_n;
  logic             tick_n;

  logic             count_down;
  logic [IDX_W-1:0] term_idx;
  logic [IDX_W-1:0] wrap_idx;
  logic             at_term;
  logic             load_ok;
  logic             wrap;

`ifdef CNT_DOWN_EN
  assign count_down = dir;
`else
  assign count_down = 1'b0;
`endif

  assign term_idx = count_down ? '0 : LAST_UP;
  assign wrap_idx = count_down ? LAST_UP : '0;
  assign at_term  = (idx == term_idx);
  assign load_ok  = ({1'b0, load_val} < (IDX_W + 1)'(SAMPLES));
  // A wrap is held off in the cycle right after a tick, which can only occur
  // when dir flips onto the new terminal; this keeps epoch_tick single-cycle.
  assign wrap     = enable && at_term && !epoch_tick;

  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign last_idx = busy && at_term;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      epoch      <= '0;
      stop_pend  <= 1'b0;
      epoch_tick <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      epoch      <= epoch_n;
      stop_pend  <= stop_pend_n;
      epoch_tick <= tick_n;
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    epoch_n     = epoch;
    stop_pend_n = stop_pend;
    tick_n      = 1'b0;

    if (clr) begin
      state_n     = IDLE;
      idx_n       = '0;
      epoch_n     = '0;
      stop_pend_n = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_n     = RUN;
            idx_n       = wrap_idx;
            epoch_n     = '0;
            stop_pend_n = 1'b0;
          end
        end
        RUN: begin
          if (stop_req) stop_pend_n = 1'b1;
          if (load_en) begin
            idx_n = load_ok ? load_val : LAST_UP;
          end else if (wrap) begin
            tick_n = 1'b1;
            if (epoch == LAST_EP || stop_pend || stop_req) begin
              state_n     = DONE;
              stop_pend_n = 1'b0;
            end else begin
              idx_n   = wrap_idx;
              epoch_n = epoch + EP_W'(1);
            end
          end else if (enable && !at_term) begin
            idx_n = count_down ? idx - IDX_W'(1) : idx + IDX_W'(1);
          end
        end
        default: begin
          state_n     = IDLE;
          idx_n       = '0;
          epoch_n     = '0;
          stop_pend_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_epoch_cnt.sv
// Scoreboard bench for sample_epoch_cnt with SAMPLES=5, MAX_EPOCHS=3.
// Driver pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_sample_epoch_cnt;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic       enable = 1'b0;
  logic       stop_req = 1'b0;
  logic       load_en = 1'b0;
  logic [3:0] load_val = 4'd0;
`ifdef CNT_DOWN_EN
  logic       dir = 1'b0;
`endif
  logic [3:0] idx;
  logic [1:0] epoch;
  logic       last_idx, epoch_tick, busy, done;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] idx;
    logic [1:0] epoch;
    logic       last_idx;
    logic       tick;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  sample_epoch_cnt #(
    .IDX_W(4), .SAMPLES(5), .EP_W(2), .MAX_EPOCHS(3)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .enable(enable),
    .stop_req(stop_req), .load_en(load_en), .load_val(load_val),
`ifdef CNT_DOWN_EN
    .dir(dir),
`endif
    .idx(idx), .epoch(epoch), .last_idx(last_idx), .epoch_tick(epoch_tick),
    .busy(busy), .done(done)
  );

  task automatic checkOutput(input exp_t ex, input string nm);
    exp_t act;
    act = '{idx: idx, epoch: epoch, last_idx: last_idx, tick: epoch_tick,
            busy: busy, done: done};
    checks++;
    if (act !== ex) begin
      failures++;
      $display("[TB] FAIL %s: got idx=%0d ep=%0d last=%b tick=%b busy=%b done=%b, want idx=%0d ep=%0d last=%b tick=%b busy=%b done=%b",
               nm, act.idx, act.epoch, act.last_idx, act.tick, act.busy, act.done,
               ex.idx, ex.epoch, ex.last_idx, ex.tick, ex.busy, ex.done);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front(), name_q.pop_front());
  end

  // One cycle: drive inputs, then queue the outputs expected after the next edge.
  task automatic applyStimulus(input logic r, c, s, e, sr, le, input logic [3:0] lv,
                               input logic [3:0] x_idx, input logic [1:0] x_ep,
                               input logic x_last, x_tick, x_busy, x_done,
                               input string nm);
    @(negedge clk);
    #1;
    rst = r; clr = c; start = s; enable = e; stop_req = sr; load_en = le; load_val = lv;
    @(posedge clk);
    #1;
    exp_q.push_back('{idx: x_idx, epoch: x_ep, last_idx: x_last, tick: x_tick,
                      busy: x_busy, done: x_done});
    name_q.push_back(nm);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    applyStimulus(1,0,0,0,0,0,0, 0,0,0,0,0,0, "reset");

    // Full run of three epochs, then enables in DONE are ignored
    applyStimulus(0,0,1,0,0,0,0, 0,0,0,0,1,0, "start");
    for (int k = 1; k <= 14; k++)
      applyStimulus(0,0,0,1,0,0,0, 4'(k % 5), 2'(k / 5), (k % 5) == 4, (k % 5) == 0, 1, 0, "run3");
    applyStimulus(0,0,0,1,0,0,0, 4,2,0,1,0,1, "finish");
    for (int k = 0; k < 3; k++)
      applyStimulus(0,0,0,1,0,0,0, 4,2,0,0,0,1, "done_hold");

    // Reset mid-run at idx=3, epoch=1
    applyStimulus(0,0,1,0,0,0,0, 0,0,0,0,1,0, "restart");
    for (int k = 1; k <= 8; k++)
      applyStimulus(0,0,0,1,0,0,0, 4'(k % 5), 2'(k / 5), (k % 5) == 4, (k % 5) == 0, 1, 0, "to_3_1");
    applyStimulus(1,0,0,1,0,0,0, 0,0,0,0,0,0, "rst_mid_run");

    // Sparse enable pattern; start in RUN ignored
    applyStimulus(0,0,1,0,0,0,0, 0,0,0,0,1,0, "start2");
    applyStimulus(0,0,0,1,0,0,0, 1,0,0,0,1,0, "pat1");
    applyStimulus(0,0,1,0,0,0,0, 1,0,0,0,1,0, "pat0_start");
    applyStimulus(0,0,0,0,0,0,0, 1,0,0,0,1,0, "pat0");
    applyStimulus(0,0,0,1,0,0,0, 2,0,0,0,1,0, "pat1b");
    applyStimulus(0,0,0,1,0,0,0, 3,0,0,0,1,0, "pat1c");

    // Parallel load and clamp
    applyStimulus(0,0,0,0,0,1,3, 3,0,0,0,1,0, "load3");
    applyStimulus(0,0,0,0,0,1,9, 4,0,1,0,1,0, "load9_clamp");
    applyStimulus(0,0,0,0,0,1,5, 4,0,1,0,1,0, "load5_clamp");
    applyStimulus(0,0,0,0,0,1,1, 1,0,0,0,1,0, "load1");
    applyStimulus(0,0,0,1,0,1,2, 2,0,0,0,1,0, "load_over_en");

    // Early stop requested mid-epoch
    applyStimulus(0,0,0,0,0,1,1, 1,0,0,0,1,0, "load1b");
    applyStimulus(0,0,0,0,1,0,0, 1,0,0,0,1,0, "stop_pulse");
    applyStimulus(0,0,0,1,0,0,0, 2,0,0,0,1,0, "stop_e1");
    applyStimulus(0,0,0,1,0,0,0, 3,0,0,0,1,0, "stop_e2");
    applyStimulus(0,0,0,1,0,0,0, 4,0,1,0,1,0, "stop_e3");
    applyStimulus(0,0,0,1,0,0,0, 4,0,0,1,0,1, "stop_done");
    applyStimulus(0,0,0,0,0,0,0, 4,0,0,0,0,1, "stop_tick_once");
    applyStimulus(0,0,1,0,0,0,0, 0,0,0,0,1,0, "start_after_stop");
    for (int k = 1; k <= 5; k++)
      applyStimulus(0,0,0,1,0,0,0, 4'(k % 5), 2'(k / 5), (k % 5) == 4, (k % 5) == 0, 1, 0, "pend_cleared");

    // Clear, IDLE ignores controls, clr beats start
    applyStimulus(0,1,0,1,0,0,0, 0,0,0,0,0,0, "clr");
    applyStimulus(0,0,0,1,1,1,3, 0,0,0,0,0,0, "idle_ignore");
    applyStimulus(0,1,1,0,0,0,0, 0,0,0,0,0,0, "clr_over_start");

    // stop_req on the wrap cycle itself
    applyStimulus(0,0,1,0,0,0,0, 0,0,0,0,1,0, "start3");
    applyStimulus(0,0,0,0,0,1,4, 4,0,1,0,1,0, "load4");
    applyStimulus(0,0,0,1,1,0,0, 4,0,0,1,0,1, "stop_on_wrap");

`ifdef CNT_DOWN_EN
    dir = 1'b1;
    applyStimulus(0,0,1,0,0,0,0, 4,0,0,0,1,0, "down_start");
    applyStimulus(0,0,0,1,0,0,0, 3,0,0,0,1,0, "down3");
    applyStimulus(0,0,0,1,0,0,0, 2,0,0,0,1,0, "down2");
    applyStimulus(0,0,0,1,0,0,0, 1,0,0,0,1,0, "down1");
    applyStimulus(0,0,0,1,0,0,0, 0,0,1,0,1,0, "down0");
    applyStimulus(0,0,0,1,0,0,0, 4,1,0,1,1,0, "down_wrap");
    dir = 1'b0;
`endif

    @(negedge clk);
    #1;
    rst = 0; clr = 0; start = 0; enable = 0; stop_req = 0; load_en = 0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
